plc_seq_axil_regs: RTL and testbench
====================================

# plc_seq_axil_regs

AXI4-Lite slave register file for the PLC sequencer IP. It terminates the S00_AXI control port driven by the processor or the AXI VIP master and holds four 32-bit read/write registers. The registers are presented to sequencer logic as a flat bus, with a per-register write strobe. It is the responder end of the AXI4-Lite link that the IP bench drives with sequential single-beat writes and reads.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width. Bits [3:2] select the register; bits [C_S_AXI_ADDR_WIDTH-1:4] must be zero.

Ports:
- s00_axi_aclk, in, 1, sole clock; all logic is on its rising edge.
- s00_axi_areset, in, 1, asynchronous, active-high reset.
- s00_axi_awaddr / awprot / awvalid / awready, in/in/in/out, ADDR/3/1/1, write address channel. awprot is ignored.
- s00_axi_wdata / wstrb / wvalid / wready, in/in/in/out, 32/4/1/1, write data channel.
- s00_axi_bresp / bvalid / bready, out/out/in, 2/1/1, write response channel.
- s00_axi_araddr / arprot / arvalid / arready, in/in/in/out, ADDR/3/1/1, read address channel. arprot is ignored.
- s00_axi_rdata / rresp / rvalid / rready, out/out/out/in, 32/2/1/1, read data channel.
- slv_regs, out, 128, {reg3, reg2, reg1, reg0}.
- reg_wr_pulse, out, 4, one-cycle strobe per register updated by a committed write.

## Operation
- Every output is registered.
- Reset values:
  - all readies low;
  - bvalid = 0, rvalid = 0;
  - bresp = 00, rresp = 00, rdata = 0;
  - slv_regs = 0, reg_wr_pulse = 0.
- Write path:
  - The AW and W channels are accepted independently into one-entry holding buffers (aw_full, w_full).
  - awready = !aw_full and wready = !w_full, except both are held low during reset.
  - Commit occurs in any cycle where aw_full && w_full && !bvalid. In that cycle:
    - decode the held address;
    - update the selected register per byte lane where wstrb[i] = 1; lanes with wstrb[i] = 0 keep their old value;
    - clear both buffers;
    - set bvalid and reg_wr_pulse[sel] for the next cycle.
- Out of range: if any upper address bit is nonzero, no register changes, reg_wr_pulse stays 0, and bresp = SLVERR (10). Otherwise bresp = OKAY (00).
- B channel: bvalid is held until bready. A pending B (bvalid && !bready) blocks the next commit. It does not block buffer fill, so at most one AW and one W are queued.
- Read path:
  - arready = !rvalid.
  - On an AR handshake, latch rdata from the selected register, or 0 with rresp = SLVERR if out of range. rvalid rises the next cycle.
  - rdata and rresp are held stable until rready. rvalid clears on the rready handshake.
- One outstanding read and one outstanding write at a time. The read and write paths are fully independent.
- Same-cycle read handshake and write commit to the same register: the read returns the pre-write value.
- Reset asserted mid-transaction:
  - all buffers and valids clear immediately (asynchronously) and registers return to 0;
  - in-flight transactions are dropped and no response is issued.

## Timing
- Readies rise on the first rising edge after s00_axi_areset deasserts.
- AW and W handshake together in cycle k, with bvalid low:
  - commit in k+1;
  - bvalid, bresp, reg_wr_pulse and the new slv_regs value all visible in k+2;
  - awready and wready are low in k+1 and high again in k+2.
- AW in cycle k, W in cycle k+n: commit in k+n+1, bvalid in k+n+2. The order of AW and W is irrelevant.
- Maximum write throughput is one write per 2 cycles with bready held high.
- AR handshake in cycle k: rvalid in k+1. With rready high in k+1, arready is high again in k+2. Maximum read throughput is one read per 2 cycles.
- reg_wr_pulse is exactly one cycle wide, coincident with the first cycle of bvalid.

## Test plan
- Reset: assert s00_axi_areset for 200 ns, then release. Require all outputs 0 during reset, and awready/wready/arready = 1 one edge after release. A read of each of 0x0, 0x4, 0x8, 0xC returns 0 with OKAY.
- Sequential fill: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC (wstrb = F), then read all four back. Require matching data, bresp and rresp = 00, and reg_wr_pulse = 0001, 0010, 0100, 1000 in order.
- Decoupled channels:
  - AW to 0x8 presented 3 cycles before W (0xDEADBEEF). Require awready low after the AW handshake, bvalid exactly 2 cycles after the W handshake, and slv_regs[95:64] = 0xDEADBEEF.
  - Repeat with W leading AW.
- Byte strobes: reg1 = 0x11223344, then write 0xAABBCCDD with wstrb = 0101. Require a read-back of 0x11BB33DD.
- Backpressure and out of range:
  - hold bready low 5 cycles after the first write, with a second AW/W queued. Require the second commit only after the first B handshake.
  - write and read 0x10. Require SLVERR on both, rdata = 0, and no register change.
- Reset mid-operation: assert reset while bvalid = 1 and rvalid = 1 (both unacknowledged). Require bvalid and rvalid low immediately, slv_regs = 0 immediately, and normal operation after release.

Source files
------------

// File: rtl/plc_seq_axil_regs.sv
// AXI4-Lite slave register file for the PLC sequencer: four 32-bit R/W
// registers exposed as a flat bus plus a per-register write strobe.
module plc_seq_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   slv_regs,
  output logic [3:0]                        reg_wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                          aw_full;
  logic                          w_full;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [DW-1:0]                 w_data_q;
  logic [NB-1:0]                 w_strb_q;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic commit;
  logic aw_full_nxt;
  logic w_full_nxt;
  logic wr_ok;
  logic rd_ok;
  logic [1:0] wr_sel;
  logic [1:0] rd_sel;
  logic unused;

  assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
  assign w_hs   = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
  assign commit = aw_full && w_full && !s00_axi_bvalid;

  assign wr_sel = aw_addr_q[3:2];
  assign rd_sel = s00_axi_araddr[3:2];
  assign wr_ok  = (aw_addr_q[C_S_AXI_ADDR_WIDTH-1:4] == '0);
  assign rd_ok  = (s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4] == '0);

  assign unused = ^{s00_axi_awprot, s00_axi_arprot, aw_addr_q[1:0], s00_axi_araddr[1:0]};

  // Next fill state of the holding buffers; a handshake can only happen while
  // a buffer is empty and a commit only while it is full, so they never collide.
  always_comb begin
    aw_full_nxt = aw_full;
    w_full_nxt  = w_full;
    if (commit) begin
      aw_full_nxt = 1'b0;
      w_full_nxt  = 1'b0;
    end else begin
      if (aw_hs) aw_full_nxt = 1'b1;
      if (w_hs)  w_full_nxt  = 1'b1;
    end
  end

  // AW/W holding buffers with registered readies derived from next fill state
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      aw_full         <= 1'b0;
      w_full          <= 1'b0;
      aw_addr_q       <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
    end else begin
      aw_full         <= aw_full_nxt;
      w_full          <= w_full_nxt;
      s00_axi_awready <= !aw_full_nxt;
      s00_axi_wready  <= !w_full_nxt;
      if (aw_hs) aw_addr_q <= s00_axi_awaddr;
      if (w_hs) begin
        w_data_q <= s00_axi_wdata;
        w_strb_q <= s00_axi_wstrb;
      end
    end
  end

  // Register commit with byte-lane strobes, write pulse and B response
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      slv_regs       <= '0;
      reg_wr_pulse   <= '0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          reg_wr_pulse <= 4'b0001 << wr_sel;
          for (int unsigned j = 0; j < NB; j++) begin
            if (w_strb_q[j]) slv_regs[int'(wr_sel)*DW + j*8 +: 8] <= w_data_q[j*8 +: 8];
          end
        end
      end else if (s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: latch data on AR handshake, hold until R handshake
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      s00_axi_rvalid  <= 1'b0;
      s00_axi_arready <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        s00_axi_rvalid  <= 1'b1;
        s00_axi_arready <= 1'b0;
        s00_axi_rdata   <= rd_ok ? slv_regs[int'(rd_sel)*DW +: DW] : '0;
        s00_axi_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_rvalid && s00_axi_rready) begin
        s00_axi_rvalid  <= 1'b0;
        s00_axi_arready <= 1'b1;
      end else begin
        s00_axi_arready <= !s00_axi_rvalid;
      end
    end
  end

endmodule

// File: tb/tb_plc_seq_axil_regs.sv
// Directed self-checking bench for plc_seq_axil_regs.
module tb_plc_seq_axil_regs;

  logic         clk;
  logic         rst;
  logic [5:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [5:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] slv_regs;
  logic [3:0]   reg_wr_pulse;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [1:0]  resp;
  logic [3:0]  pulse;
  logic [31:0] rd;

  plc_seq_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .s00_axi_aclk(clk),       .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
    .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .s00_axi_araddr(araddr),  .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata),    .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid),  .s00_axi_rready(rready),
    .slv_regs(slv_regs),      .reg_wr_pulse(reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    fails++;
    $error("FAIL %s: observed timeout expected response", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r, output logic [3:0] p);
    bit awd;
    bit wd;
    int n;
    awd = 0; wd = 0; n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    while (!(awd && wd) && n < 50) begin
      if (awvalid && awready) awd = 1;
      if (wvalid && wready) wd = 1;
      tick(); n++;
      if (awd) awvalid = 0;
      if (wd) wvalid = 0;
    end
    while (!bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("wr_timeout");
    r = bresp; p = reg_wr_pulse;
    awvalid = 0; wvalid = 0;
    tick();
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    bit ard;
    int n;
    ard = 0; n = 0;
    araddr = a; arvalid = 1; rready = 1;
    while (!ard && n < 50) begin
      if (arvalid && arready) ard = 1;
      tick(); n++;
    end
    arvalid = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("rd_timeout");
    d = rdata; r = rresp;
    tick();
  endtask

  initial begin
    rst = 1; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;

    // Reset state
    #100;
    check("rst_ctrl", {awready, wready, arready, bvalid, rvalid, bresp, rresp, reg_wr_pulse}, '0);
    check("rst_rdata", rdata, '0);
    check("rst_regs", slv_regs, '0);
    #100;
    rst = 0;
    tick();
    check("rst_readies", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 4; i++) begin
      axi_read(6'(i * 4), rd, resp);
      check("rst_read", {resp, rd}, 34'h0);
    end

    // Sequential fill
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(i * 4), 32'(i + 1), 4'hF, resp, pulse);
      check("fill_bresp", resp, 2'b00);
      check("fill_pulse", pulse, 4'b0001 << i);
    end
    check("fill_regs", slv_regs, {32'h4, 32'h3, 32'h2, 32'h1});
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(i * 4), rd, resp);
      check("fill_read", {resp, rd}, {2'b00, 32'(i + 1)});
    end

    // AW leads W by 3 cycles
    bready = 1; awaddr = 6'h08; awvalid = 1;
    check("dec_aw_ready", awready, 1'b1);
    tick(); awvalid = 0;
    check("dec_aw_held", awready, 1'b0);
    tick(); tick();
    check("dec_aw_wait", {awready, bvalid}, 2'b00);
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    tick(); wvalid = 0;
    check("dec_commit_cyc", bvalid, 1'b0);
    tick();
    check("dec_b", {bvalid, bresp, reg_wr_pulse}, {1'b1, 2'b00, 4'b0100});
    check("dec_reg2", slv_regs[95:64], 32'hDEADBEEF);
    tick();
    check("dec_after", {bvalid, reg_wr_pulse, awready, wready}, {1'b0, 4'b0000, 2'b11});

    // W leads AW by 3 cycles
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
    tick(); wvalid = 0;
    check("decw_w_held", wready, 1'b0);
    tick(); tick();
    awaddr = 6'h08; awvalid = 1;
    tick(); awvalid = 0;
    check("decw_commit_cyc", bvalid, 1'b0);
    tick();
    check("decw_b", {bvalid, bresp, reg_wr_pulse}, {1'b1, 2'b00, 4'b0100});
    check("decw_reg2", slv_regs[95:64], 32'h12345678);
    tick();

    // Byte strobes
    axi_write(6'h04, 32'h11223344, 4'hF, resp, pulse);
    axi_write(6'h04, 32'hAABBCCDD, 4'b0101, resp, pulse);
    check("strb_pulse", {resp, pulse}, {2'b00, 4'b0010});
    axi_read(6'h04, rd, resp);
    check("strb_read", {resp, rd}, {2'b00, 32'h11BB33DD});

    // B backpressure with a second write queued
    bready = 0; awaddr = 6'h00; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    check("bp_rdy_low", {awready, wready}, 2'b00);
    awaddr = 6'h0C; wdata = 32'h66; awvalid = 1; wvalid = 1;
    tick();
    check("bp_b1", {bvalid, reg_wr_pulse}, 5'b1_0001);
    check("bp_reg0", slv_regs[31:0], 32'h55);
    tick();
    awvalid = 0; wvalid = 0;
    check("bp_queued", {awready, wready, reg_wr_pulse}, 6'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold", {bvalid, reg_wr_pulse, slv_regs[127:96]}, {1'b1, 4'b0000, 32'h4});
    end
    bready = 1;
    tick();
    check("bp_b_done", {bvalid, slv_regs[127:96]}, {1'b0, 32'h4});
    tick();
    check("bp_b2", {bvalid, bresp, reg_wr_pulse}, {1'b1, 2'b00, 4'b1000});
    check("bp_reg3", slv_regs[127:96], 32'h66);
    tick();

    // Out of range
    axi_write(6'h10, 32'hFFFFFFFF, 4'hF, resp, pulse);
    check("oor_wr", {resp, pulse}, {2'b10, 4'b0000});
    check("oor_regs", slv_regs, {32'h66, 32'h12345678, 32'h11BB33DD, 32'h55});
    axi_read(6'h10, rd, resp);
    check("oor_rd", {resp, rd}, {2'b10, 32'h0});

    // Reset with B and R both pending
    bready = 0; rready = 0;
    awaddr = 6'h00; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 6'h04; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    tick();
    check("mid_pending", {bvalid, rvalid}, 2'b11);
    #1 rst = 1;
    #1;
    check("mid_valids", {bvalid, rvalid, awready, wready, arready}, 5'b0);
    check("mid_regs", slv_regs, '0);
    rst = 0;
    tick();
    check("mid_readies", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    axi_write(6'h08, 32'h99, 4'hF, resp, pulse);
    check("mid_wr", {resp, pulse}, {2'b00, 4'b0100});
    axi_read(6'h08, rd, resp);
    check("mid_rd", {resp, rd}, {2'b00, 32'h99});
    check("mid_regs_after", slv_regs, {32'h0, 32'h99, 32'h0, 32'h0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
